// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between instruction fetch (I) and load/store (D).
// Latency: request seen in IDLE -> mem_req next cycle; x_ack 1 cycle after mem_ack; 3+k cycles per access.
// Backpressure: requesters hold x_req until x_ack; memory stalls by delaying mem_ack.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_req/i_addr        fetch request (read-only); i_ack/i_rdata completion
//   d_req/d_we/d_addr/d_wdata  load/store request; d_ack/d_rdata completion
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request, held until mem_ack
//   mem_rdata/mem_ack   memory response
//   busy                high while a transaction is in WAIT or RESP
//   grant_d             owner of current/last transaction (1 = D)
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          grant_d
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          grant_d_q, grant_d_d;

  // Fetch wins only when it is alone, or when data has monopolised the
  // port for STARVE_LIMIT consecutive grants while fetch was waiting.
  logic pick_i;
  assign pick_i = i_req && (!d_req || (streak_q == LIMIT));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d_d   = grant_d_q;

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          mem_req_d = 1'b1;
          state_d   = WAIT;
          if (pick_i) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            grant_d_d   = 1'b0;
            streak_d    = '0;
          end else begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            grant_d_d   = 1'b1;
            // Only count grants that actually made a fetch wait.
            if (i_req) begin
              if (streak_q != LIMIT) begin
                streak_d = streak_q + SW'(1);
              end
            end else begin
              streak_d = '0;
            end
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (grant_d_q) begin
            d_ack_d = 1'b1;
            // Stores leave the last load data untouched.
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end

      RESP: begin
        // Requests are not sampled here: the requester only sees its ack
        // this cycle, so its req line still reflects the finished access.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      grant_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
      grant_d_q   <= grant_d_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign grant_d   = grant_d_q;

endmodule
